// File: rtl/mesi_isc_breq_arb_n.sv
// mesi_isc_breq_arb_n
//   N-CPU breq controller for the MESI ISC. Acknowledges mbus broadcast
//   commands into per-CPU breq fifos, tags each breq with type, CPU index and
//   a unique breq ID, and arbitrates the non-empty breq fifos into the single
//   broad fifo.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   arb_mode_i               0 = round-robin, 1 = fixed priority (lowest index)
//   chan_en_i                per-channel enable
//   mbus_cmd_array_i         per-CPU mbus command
//   fifo_status_*_array_i    breq fifo empty / full flags
//   broad_fifo_status_full_i broad fifo full
//   broad_*_array_i          breq fifo head address / type / ID
//   mbus_ack_array_o         mbus acknowledge (1-cycle pulse)
//   fifo_wr_array_o          breq fifo write (same as ack)
//   fifo_rd_array_o          breq fifo read, one-hot or zero
//   broad_fifo_wr_o          broad fifo write
//   broad_*_o                selected breq fields
//   breq_*_array_o           per-channel breq tag fields
//   starve_o                 channel has lost STARVE_LIMIT grants in a row
module mesi_isc_breq_arb_n #(
  parameter int CPU_COUNT        = 4,
  parameter int CPU_ID_WIDTH     = 2,
  parameter int MBUS_CMD_WIDTH   = 3,
  parameter int ADDR_WIDTH       = 32,
  parameter int BROAD_TYPE_WIDTH = 2,
  parameter int BROAD_ID_WIDTH   = 7,
  parameter int STARVE_LIMIT     = 8,
  parameter int WAIT_WIDTH       = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   arb_mode_i,
  input  logic [CPU_COUNT-1:0]                   chan_en_i,
  input  logic [CPU_COUNT*MBUS_CMD_WIDTH-1:0]    mbus_cmd_array_i,
  input  logic [CPU_COUNT-1:0]                   fifo_status_empty_array_i,
  input  logic [CPU_COUNT-1:0]                   fifo_status_full_array_i,
  input  logic                                   broad_fifo_status_full_i,
  input  logic [CPU_COUNT*ADDR_WIDTH-1:0]        broad_addr_array_i,
  input  logic [CPU_COUNT*BROAD_TYPE_WIDTH-1:0]  broad_type_array_i,
  input  logic [CPU_COUNT*BROAD_ID_WIDTH-1:0]    broad_id_array_i,
  output logic [CPU_COUNT-1:0]                   mbus_ack_array_o,
  output logic [CPU_COUNT-1:0]                   fifo_wr_array_o,
  output logic [CPU_COUNT-1:0]                   fifo_rd_array_o,
  output logic                                   broad_fifo_wr_o,
  output logic [ADDR_WIDTH-1:0]                  broad_addr_o,
  output logic [BROAD_TYPE_WIDTH-1:0]            broad_type_o,
  output logic [CPU_ID_WIDTH-1:0]                broad_cpu_id_o,
  output logic [BROAD_ID_WIDTH-1:0]              broad_id_o,
  output logic [CPU_COUNT*BROAD_TYPE_WIDTH-1:0]  breq_type_array_o,
  output logic [CPU_COUNT*CPU_ID_WIDTH-1:0]      breq_cpu_id_array_o,
  output logic [CPU_COUNT*BROAD_ID_WIDTH-1:0]    breq_id_array_o,
  output logic [CPU_COUNT-1:0]                   starve_o
);

  localparam int BASE_WIDTH = BROAD_ID_WIDTH - CPU_ID_WIDTH;

  localparam logic [MBUS_CMD_WIDTH-1:0]   MBUS_CMD_WR_BROAD = MBUS_CMD_WIDTH'(3);
  localparam logic [MBUS_CMD_WIDTH-1:0]   MBUS_CMD_RD_BROAD = MBUS_CMD_WIDTH'(4);
  localparam logic [BROAD_TYPE_WIDTH-1:0] BREQ_TYPE_NOP     = BROAD_TYPE_WIDTH'(0);
  localparam logic [BROAD_TYPE_WIDTH-1:0] BREQ_TYPE_WR      = BROAD_TYPE_WIDTH'(1);
  localparam logic [BROAD_TYPE_WIDTH-1:0] BREQ_TYPE_RD      = BROAD_TYPE_WIDTH'(2);

  logic [CPU_COUNT-1:0]                  ack_q, ack_d;
  logic [CPU_COUNT*BROAD_TYPE_WIDTH-1:0] breq_type_q, breq_type_d;
  logic [BASE_WIDTH-1:0]                 breq_id_base_q, breq_id_base_d;
  logic [CPU_COUNT-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [WAIT_WIDTH-1:0]                 wait_q [CPU_COUNT];
  logic [WAIT_WIDTH-1:0]                 wait_d [CPU_COUNT];

  logic [CPU_COUNT-1:0]    req;
  logic [CPU_COUNT-1:0]    grant;
  logic                    grant_vld;
  logic [CPU_ID_WIDTH-1:0] grant_idx;

  // Ack and breq type. An ack is never repeated in the next cycle, so a held
  // command is acknowledged every other cycle.
  always_comb begin
    ack_d       = '0;
    breq_type_d = '0;
    for (int i = 0; i < CPU_COUNT; i++) begin
      logic [MBUS_CMD_WIDTH-1:0] cmd;
      logic is_wr, is_rd;
      cmd   = mbus_cmd_array_i[i*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH];
      is_wr = (cmd == MBUS_CMD_WR_BROAD);
      is_rd = (cmd == MBUS_CMD_RD_BROAD);
      ack_d[i] = ~ack_q[i] & chan_en_i[i] & ~fifo_status_full_array_i[i] & (is_wr | is_rd);
      breq_type_d[i*BROAD_TYPE_WIDTH +: BROAD_TYPE_WIDTH] =
        is_wr ? BREQ_TYPE_WR : (is_rd ? BREQ_TYPE_RD : BREQ_TYPE_NOP);
    end
  end

  // One new base per write cycle; wraps naturally at the field width.
  always_comb begin
    breq_id_base_d = breq_id_base_q;
    if (|ack_q) breq_id_base_d = breq_id_base_q + BASE_WIDTH'(1);
  end

  genvar gi;
  generate
    for (gi = 0; gi < CPU_COUNT; gi++) begin : g_chan
      assign req[gi]      = ~fifo_status_empty_array_i[gi] & chan_en_i[gi];
      assign starve_o[gi] = (wait_q[gi] == WAIT_WIDTH'(STARVE_LIMIT));
      assign grant[gi]    = grant_vld & (grant_idx == CPU_ID_WIDTH'(gi));
      assign breq_cpu_id_array_o[gi*CPU_ID_WIDTH +: CPU_ID_WIDTH] = CPU_ID_WIDTH'(gi);
      assign breq_id_array_o[gi*BROAD_ID_WIDTH +: BROAD_ID_WIDTH] =
        {breq_id_base_q, CPU_ID_WIDTH'(gi)};
    end
  endgenerate

  // Grant selection. Descending loops leave the lowest index (or smallest
  // offset from the round-robin pointer) as the final winner.
  always_comb begin
    int rr_idx;
    int idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_idx    = 0;
    idx       = 0;
    for (int i = 0; i < CPU_COUNT; i++) begin
      if (rr_ptr_q[i]) rr_idx = i;
    end
    for (int i = CPU_COUNT - 1; i >= 0; i--) begin
      if (req[i] && starve_o[i]) begin
        grant_vld = 1'b1;
        grant_idx = CPU_ID_WIDTH'(i);
      end
    end
    if (!grant_vld) begin
      if (arb_mode_i) begin
        for (int i = CPU_COUNT - 1; i >= 0; i--) begin
          if (req[i]) begin
            grant_vld = 1'b1;
            grant_idx = CPU_ID_WIDTH'(i);
          end
        end
      end else begin
        for (int k = CPU_COUNT - 1; k >= 0; k--) begin
          idx = (rr_idx + k) % CPU_COUNT;
          if (req[idx]) begin
            grant_vld = 1'b1;
            grant_idx = CPU_ID_WIDTH'(idx);
          end
        end
      end
    end
  end

  assign fifo_rd_array_o = grant & {CPU_COUNT{~broad_fifo_status_full_i}};
  assign broad_fifo_wr_o = |fifo_rd_array_o;
  assign broad_cpu_id_o  = grant_idx;

  // One-hot AND-OR mux; zero when nothing is granted.
  always_comb begin
    broad_addr_o = '0;
    broad_type_o = '0;
    broad_id_o   = '0;
    for (int i = 0; i < CPU_COUNT; i++) begin
      broad_addr_o = broad_addr_o |
        ({ADDR_WIDTH{grant[i]}} & broad_addr_array_i[i*ADDR_WIDTH +: ADDR_WIDTH]);
      broad_type_o = broad_type_o |
        ({BROAD_TYPE_WIDTH{grant[i]}} & broad_type_array_i[i*BROAD_TYPE_WIDTH +: BROAD_TYPE_WIDTH]);
      broad_id_o   = broad_id_o |
        ({BROAD_ID_WIDTH{grant[i]}} & broad_id_array_i[i*BROAD_ID_WIDTH +: BROAD_ID_WIDTH]);
    end
  end

  // Pointer and wait counters only move on an actual broad write, so a full
  // broad fifo freezes them.
  always_comb begin
    int nxt;
    nxt      = (int'(grant_idx) + 1) % CPU_COUNT;
    rr_ptr_d = rr_ptr_q;
    if (broad_fifo_wr_o) begin
      rr_ptr_d      = '0;
      rr_ptr_d[nxt] = 1'b1;
    end
    for (int i = 0; i < CPU_COUNT; i++) begin
      wait_d[i] = wait_q[i];
      if (!req[i] || fifo_rd_array_o[i]) begin
        wait_d[i] = '0;
      end else if (broad_fifo_wr_o && !starve_o[i]) begin
        wait_d[i] = wait_q[i] + WAIT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q          <= '0;
      breq_type_q    <= '0;
      breq_id_base_q <= '0;
      rr_ptr_q       <= CPU_COUNT'(1);
      for (int i = 0; i < CPU_COUNT; i++) wait_q[i] <= '0;
    end else begin
      ack_q          <= ack_d;
      breq_type_q    <= breq_type_d;
      breq_id_base_q <= breq_id_base_d;
      rr_ptr_q       <= rr_ptr_d;
      for (int i = 0; i < CPU_COUNT; i++) wait_q[i] <= wait_d[i];
    end
  end

  assign mbus_ack_array_o  = ack_q;
  assign fifo_wr_array_o   = ack_q;
  assign breq_type_array_o = breq_type_q;

endmodule

// File: doc/mesi_isc_breq_arb_n.md
Name: mesi_isc_breq_arb_n

Overview:
- Parametrised N-CPU successor of the four-fifo breq controller in mesi_isc.
- Acks mbus broadcast commands into per-CPU breq fifos and tags each breq with type, CPU ID and unique breq ID.
- Arbitrates the non-empty breq fifos into the single broad fifo.
- Additions: selectable arbitration mode, per-channel enable mask, true round-robin pointer and starvation guard.

Parameters:
- CPU_COUNT, 4, number of CPU channels (2..16).
- CPU_ID_WIDTH, 2, width of CPU index; equals $clog2(CPU_COUNT).
- MBUS_CMD_WIDTH, 3, mbus command width.
- ADDR_WIDTH, 32, broadcast address width.
- BROAD_TYPE_WIDTH, 2, breq/broad type width.
- BROAD_ID_WIDTH, 7, breq ID width; must exceed CPU_ID_WIDTH.
- STARVE_LIMIT, 8, number of lost grants after which a waiting channel is forced.
- WAIT_WIDTH, 4, wait counter width; 2^WAIT_WIDTH > STARVE_LIMIT.

Ports:
- clk  in  1  system clock
- rst  in  1  reset: asynchronous, active-high
- arb_mode_i  in  1  0 = round-robin, 1 = fixed priority (lowest index wins)
- chan_en_i  in  CPU_COUNT  per-channel enable
- mbus_cmd_array_i  in  CPU_COUNT*MBUS_CMD_WIDTH  per-CPU mbus command
- fifo_status_empty_array_i  in  CPU_COUNT  breq fifo empty flags
- fifo_status_full_array_i  in  CPU_COUNT  breq fifo full flags
- broad_fifo_status_full_i  in  1  broad fifo full
- broad_addr_array_i  in  CPU_COUNT*ADDR_WIDTH  breq fifo head address
- broad_type_array_i  in  CPU_COUNT*BROAD_TYPE_WIDTH  breq fifo head type
- broad_id_array_i  in  CPU_COUNT*BROAD_ID_WIDTH  breq fifo head ID
- mbus_ack_array_o  out  CPU_COUNT  mbus acknowledge
- fifo_wr_array_o  out  CPU_COUNT  breq fifo write
- fifo_rd_array_o  out  CPU_COUNT  breq fifo read (one-hot or zero)
- broad_fifo_wr_o  out  1  broad fifo write
- broad_addr_o  out  ADDR_WIDTH  selected address
- broad_type_o  out  BROAD_TYPE_WIDTH  selected type
- broad_cpu_id_o  out  CPU_ID_WIDTH  selected channel index
- broad_id_o  out  BROAD_ID_WIDTH  selected breq ID
- breq_type_array_o  out  CPU_COUNT*BROAD_TYPE_WIDTH  registered breq type per channel
- breq_cpu_id_array_o  out  CPU_COUNT*CPU_ID_WIDTH  constant channel index i
- breq_id_array_o  out  CPU_COUNT*BROAD_ID_WIDTH  breq ID per channel
- starve_o  out  CPU_COUNT  channel at STARVE_LIMIT

Behaviour:
- Encodings (mesi_isc_define): MBUS_CMD_WR_BROAD = 3, RD_BROAD = 4; BREQ_TYPE NOP = 0, WR = 1, RD = 2.
- Reset values: all registered outputs 0, rr_ptr = one-hot bit 0, wait counters 0, breq_id_base 0.
- Ack:
  - ack[i] next = ~ack[i] & chan_en_i[i] & ~full[i] & (cmd_i is WR_BROAD or RD_BROAD).
  - Ack is a 1-cycle pulse and is never asserted in back-to-back cycles; a held command is acked every other cycle.
  - fifo_wr_array_o = mbus_ack_array_o.
- breq_type[i] is registered each cycle from cmd_i: WR_BROAD -> 1, RD_BROAD -> 2, else 0. It is aligned with ack.
- breq ID:
  - breq_id[i] = {breq_id_base, i[CPU_ID_WIDTH-1:0]}.
  - breq_id_base increments by 1 on any cycle with |fifo_wr_array_o, and wraps to 0 modulo 2^(BROAD_ID_WIDTH-CPU_ID_WIDTH).
- Arbitration (combinational, same cycle):
  - req[i] = ~empty[i] & chan_en_i[i].
  - If any requesting channel has starve_o set, the lowest-index such channel wins regardless of mode.
  - Else if arb_mode_i = 1: lowest-index request wins.
  - Else: first request at or after rr_ptr, wrapping from CPU_COUNT-1 to 0.
- Read/write:
  - fifo_rd_array_o = grant & ~broad_fifo_status_full_i.
  - broad_fifo_wr_o = |fifo_rd_array_o.
  - Broad data muxes are one-hot AND-OR; all zero when there is no grant.
- rr_ptr: on broad_fifo_wr_o, rr_ptr moves to one-hot of (granted index + 1) mod CPU_COUNT. It updates in both modes and holds otherwise.
- Wait counter[i]:
  - Clears on grant to i, or when req[i] = 0.
  - Increments (saturating at STARVE_LIMIT) when req[i] = 1 and broad_fifo_wr_o grants another channel.
  - starve_o[i] = (counter[i] == STARVE_LIMIT).
- Broad fifo full: no reads, no writes; rr_ptr and counters hold.
- Disabled channel: no ack, no grant, counter 0. A pending ack still completes its single pulse.
- Mode change mid-stream takes effect on the next combinational grant; no state is flushed.
- Reset mid-operation: everything returns to reset values immediately (asynchronous); in-flight acks are dropped.

Test Plan:
- Reset, then ch1 cmd=3 held 4 cycles with full=0 -> ack[1] pulses at cycles 1 and 3; breq_type[1]=1; breq_id[1] = 0x01, then 0x05.
- RR, all four fifos non-empty, broad not full -> grants 0,1,2,3,0; broad_cpu_id_o follows that order.
- Fixed mode, ch0 and ch3 always non-empty -> ch0 wins 8 times, starve_o[3]=1, next grant ch3, then starve_o[3]=0.
- broad_fifo_status_full_i=1 with ch2 non-empty -> fifo_rd=0, broad_fifo_wr_o=0, rr_ptr unchanged; deassert -> ch2 read same cycle.
- chan_en_i=4'b1011, ch2 cmd=4 and non-empty -> no ack[2], never granted; other channels are arbitrated normally.
- breq_id_base at 31 (BROAD_ID_WIDTH=7), ack to ch3 -> base wraps to 0; breq_id[3] goes from 0x7F to 0x03.
